// File: rtl/uart_frame_sender.sv
// rtl/uart_frame_sender.sv - packet-to-UART serializer: 8 data bits, optional parity, one stop bit, optional inter-byte gap
module uart_frame_sender #(
    parameter int NBYTES       = 14,
    parameter int CLKS_PER_BIT = 27,
    parameter int GAP_CLKS     = 0,
    parameter int PARITY       = 0
) (
    input  logic                          clk_3125,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(NBYTES+1)-1:0]   len,
    input  logic [8*NBYTES-1:0]           data_in,
    output logic                          busy,
    output logic                          done,
    output logic                          tx
);

    localparam int LW   = $clog2(NBYTES + 1);
    localparam int MAXC = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
    localparam int TW   = $clog2(MAXC);

    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [LW-1:0] NB_MAX   = LW'(NBYTES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        GAP        = 3'd5,
        FINISH     = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [LW-1:0]       byte_idx_q, byte_idx_d;
    logic [LW-1:0]       len_eff_q, len_eff_d;
    logic [8*NBYTES-1:0] data_q, data_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_end;
    logic                last_byte;

    assign bit_end   = (timer_q == BIT_LAST);
    assign last_byte = ((byte_idx_q + LW'(1)) == len_eff_q);

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            len_eff_q  <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            len_eff_q  <= len_eff_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The active byte always sits in data_q[7:0]; the packet shifts down one byte per frame.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        len_eff_d  = len_eff_q;
        data_d     = data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d    = START_BIT;
                        data_d     = data_in;
                        len_eff_d  = (len > NB_MAX) ? NB_MAX : len;
                        byte_idx_d = '0;
                        bit_idx_d  = '0;
                        timer_d    = '0;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA_BITS;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY != 0) ? PARITY_BIT : STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PARITY_BIT: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = STOP_BIT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (last_byte) begin
                        state_d = FINISH;
                    end else begin
                        byte_idx_d = byte_idx_q + LW'(1);
                        data_d     = data_q >> 8;
                        state_d    = (GAP_CLKS > 0) ? GAP : START_BIT;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = START_BIT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so tx/busy/done come straight from flops.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            START_BIT: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA_BITS: begin
                tx_d   = data_d[bit_idx_d];
                busy_d = 1'b1;
            end
            PARITY_BIT: begin
                tx_d   = (PARITY == 2) ? ~(^data_d[7:0]) : (^data_d[7:0]);
                busy_d = 1'b1;
            end
            STOP_BIT, GAP: begin
                busy_d = 1'b1;
            end
            FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 SHALL have parameter NBYTES, default 14: maximum bytes per packet, legal range 1..64.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 27: clocks per bit (3.125 MHz / 115200 baud), legal range ≥2.
REQ-003 SHALL have parameter GAP_CLKS, default 0: idle-high clocks inserted between consecutive bytes of one packet, legal range ≥0.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 clk_3125  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  packet request, sampled only in IDLE.
REQ-008 len  input  clog2(NBYTES+1)  number of bytes to send, sampled with start.
REQ-009 data_in  input  8*NBYTES  packet bytes; byte k occupies bits [8k+7:8k], byte 0 sent first.
REQ-010 busy  output  1  high from the cycle after start is accepted until packet completion.
REQ-011 done  output  1  one-cycle pulse on packet completion.
REQ-012 tx  output  1  serial line, registered, idle high.

Function
REQ-013 SHALL implement states IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, GAP, FINISH.
REQ-014 IDLE with start=1 and len≠0 SHALL latch data_in and len_eff=min(len,NBYTES), clear the byte index, and go to START_BIT; tx=0 and busy=1 from the next cycle.
REQ-015 IDLE with start=1 and len=0 SHALL go to FINISH, transmit nothing, and pulse done one cycle later; busy stays 0.
REQ-016 start while busy SHALL be ignored; data_in/len changes while busy SHALL NOT affect the packet in flight.
REQ-017 Each bit (start, 8 data bits LSB first, optional parity, one stop bit=1) SHALL hold tx for exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads on every bit boundary.
REQ-018 PARITY_BIT SHALL be skipped when PARITY=0; when 1, tx=XOR of the 8 data bits; when 2, its inverse.
REQ-019 After STOP_BIT, if bytes remain: go to GAP when GAP_CLKS>0 (tx=1 for exactly GAP_CLKS cycles), otherwise go directly to START_BIT of the next byte, with no idle cycle.
REQ-020 After the STOP_BIT of the last byte, no GAP SHALL be inserted; go to FINISH for one cycle with done=1, busy=0, tx=1, then return to IDLE.
REQ-021 A start asserted in the FINISH cycle SHALL be ignored; it is accepted only from the following IDLE cycle.
REQ-022 Packet duration from the first tx=0 to done SHALL be N*B*CLKS_PER_BIT + (N-1)*GAP_CLKS cycles, where B=10 (PARITY=0) or 11; done is asserted in the cycle that follows.
REQ-023 The byte index and bit counters SHALL be sized so len_eff=NBYTES does not wrap before the last byte.

Reset
REQ-024 rst_n=0 SHALL immediately force tx=1, busy=0, done=0, state=IDLE, and clear all counters, including mid-byte; a partial frame is abandoned without a stop bit.
REQ-025 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-026 Defaults, len=1, byte 0=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 27 cycles; done 270 cycles after the first tx=0.
REQ-027 PARITY=1, len=2, bytes 8'h01 and 8'h03, GAP_CLKS=5 -> parity bits 1 and 0; 5 high cycles between the bytes; done at 2*297+5 cycles.
REQ-028 len=20 with NBYTES=14 -> exactly 14 bytes sent; len=0 -> done pulse with tx held high.
REQ-029 start pulsed mid-packet and data_in changed mid-packet -> no effect; original bytes sent once.
REQ-030 rst_n low during data bit 3 of byte 2 -> tx=1 asynchronously; a new start after release sends a clean packet.
REQ-031 Back-to-back packets with start held high -> second packet begins on the IDLE cycle after FINISH, with no overlap.
